operand_skewer: RTL

Transmit side of the systolic array's operand interface. Accepts one A column-vector and one B row-vector per handshake from the unified-buffer read path. Drives the array's left edge (`input_data`) and top edge (`weight_data`) with lane i delayed i cycles relative to lane 0. Generates `input_first`/`input_last`/`weight_first`/`weight_last`, `acc_clear` and `compute_enable`, and holds compute until the array reports `all_done`.

---
 rtl/operand_skewer_pkg.sv | 22 ++
 rtl/operand_skewer_delay.sv | 38 +++
 rtl/operand_skewer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/operand_skewer_pkg.sv
// Shared types and sizing for the systolic-array operand path.
package operand_skewer_pkg;

  localparam int ARRAY_SIZE = 4;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    PREC_INT8,
    PREC_INT16,
    PREC_FP16
  } precision_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_FLUSH,
    S_WAIT_DONE,
    S_DONE
  } skew_state_t;

endpackage

// File: rtl/operand_skewer_delay.sv
// Fixed-depth shift register: a value loaded at d appears on q DEPTH cycles later.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Every stage advances every cycle; stage 0 takes the new input.
  always_comb begin
    stage_d[0] = d;
    for (int j = 1; j < DEPTH; j++) begin
      stage_d[j] = stage_q[j-1];
    end
  end

  // Stage registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        stage_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        stage_q[j] <= stage_d[j];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/operand_skewer.sv
// Skews A/B operand vectors onto the systolic array edges and sequences a tile.
module operand_skewer
  import operand_skewer_pkg::*;
#(
  parameter int N  = ARRAY_SIZE,
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a [N],
  input  logic [DW-1:0] in_b [N],
  input  logic          in_last,
  input  logic          all_done_in,
  output logic [DW-1:0] input_data [N],
  output logic [DW-1:0] weight_data [N],
  output logic          input_first,
  output logic          weight_first,
  output logic          input_last,
  output logic          weight_last,
  output logic          acc_clear,
  output logic          compute_enable,
  output logic          busy,
  output logic          done
);

  // Flush counter counts 0..N-2.
  localparam int CW = (N > 2) ? $clog2(N - 1) : 1;

  skew_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_pend_q, first_pend_d;
  logic          ce_q, ce_d;
  logic          hs;
  logic          first_mark, last_mark;
  logic [DW-1:0] lane_a_d [N];
  logic [DW-1:0] lane_b_d [N];

  assign hs = (state_q == S_STREAM) && in_valid;

  // Tile sequencing, first-element tracking and compute-enable window.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    first_pend_d = first_pend_q;
    ce_d         = ce_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM: begin
        state_d      = S_STREAM;
        first_pend_d = 1'b1;
      end
      S_STREAM: begin
        if (hs && in_last) begin
          cnt_d   = '0;
          state_d = (N > 1) ? S_FLUSH : S_WAIT_DONE;
        end
      end
      S_FLUSH: begin
        if (cnt_q == CW'(N - 2)) state_d = S_WAIT_DONE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_WAIT_DONE: begin
        if (all_done_in) begin
          state_d = S_DONE;
          ce_d    = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (hs) first_pend_d = 1'b0;
    if (hs && first_pend_q) ce_d = 1'b1;
  end

  // Control registers; a reset aborts any tile in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      first_pend_q <= 1'b0;
      ce_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      first_pend_q <= first_pend_d;
      ce_q         <= ce_d;
    end
  end

  // Lane inputs: accepted operands on a handshake, zeros otherwise.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane_a_d[i] = hs ? in_a[i] : '0;
      lane_b_d[i] = hs ? in_b[i] : '0;
    end
  end

  assign first_mark = hs && first_pend_q;
  assign last_mark  = hs && in_last;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      skew_delay_line #(.DEPTH(gi + 1), .WIDTH(DW)) u_a (
        .clk (clk),
        .rst (rst),
        .d   (lane_a_d[gi]),
        .q   (input_data[gi])
      );
      skew_delay_line #(.DEPTH(gi + 1), .WIDTH(DW)) u_b (
        .clk (clk),
        .rst (rst),
        .d   (lane_b_d[gi]),
        .q   (weight_data[gi])
      );
    end
  endgenerate

  // First marker rides with lane 0, last marker with lane N-1.
  skew_delay_line #(.DEPTH(1), .WIDTH(1)) u_first (
    .clk (clk),
    .rst (rst),
    .d   (first_mark),
    .q   (input_first)
  );

  skew_delay_line #(.DEPTH(N), .WIDTH(1)) u_last (
    .clk (clk),
    .rst (rst),
    .d   (last_mark),
    .q   (input_last)
  );

  assign weight_first   = input_first;
  assign weight_last    = input_last;
  assign in_ready       = (state_q == S_STREAM);
  assign acc_clear      = (state_q == S_ARM);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign compute_enable = ce_q;

endmodule
